// File: rtl/mem_wb_stage_pkg.sv
// MEM/WB stage shared types and default widths.
// The beat struct and bubble constant are shared with the writeback side.
package mem_wb_stage_pkg;

  localparam int MW_DATA_W = 16;
  localparam int MW_REG_W  = 4;
  localparam int MW_SRC_N  = 2;

  localparam logic [MW_REG_W-1:0] MW_NOP_DST = '1;

  typedef struct packed {
    logic                 memtoreg;
    logic [MW_REG_W-1:0]  regdst;
    logic                 regwrite;
    logic [MW_DATA_W-1:0] alures;
    logic [MW_DATA_W-1:0] memres;
  } mw_beat_t;

  localparam mw_beat_t MW_BUBBLE = '{
    memtoreg: 1'b0,
    regdst:   MW_NOP_DST,
    regwrite: 1'b0,
    alures:   '0,
    memres:   '0
  };

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side beat in, WB-side beat out,
// plus the hazard-unit forwarding compare.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W    = MW_DATA_W,
    parameter int REG_W     = MW_REG_W,
    parameter int SRC_PORTS = MW_SRC_N
);

    logic                       in_valid;
    logic                       in_ready;
    logic                       flush;
    logic                       memtoreg_i;
    logic [REG_W-1:0]           regdst_i;
    logic                       regwrite_i;
    logic [DATA_W-1:0]          alures_i;
    logic [DATA_W-1:0]          memres_i;

    logic                       out_valid;
    logic                       out_ready;
    logic                       memtoreg_o;
    logic [REG_W-1:0]           regdst_o;
    logic                       regwrite_o;
    logic [DATA_W-1:0]          alures_o;
    logic [DATA_W-1:0]          memres_o;
    logic [DATA_W-1:0]          wb_data_o;

    logic [SRC_PORTS*REG_W-1:0] fwd_src_i;
    logic [SRC_PORTS-1:0]       fwd_hit_o;
    logic [1:0]                 occupancy_o;

    modport slave (
        input  in_valid, flush, memtoreg_i, regdst_i,
        input  regwrite_i, alures_i, memres_i,
        input  out_ready, fwd_src_i,
        output in_ready, out_valid, memtoreg_o, regdst_o,
        output regwrite_o, alures_o, memres_o, wb_data_o,
        output fwd_hit_o, occupancy_o
    );

    modport master (
        output in_valid, flush, memtoreg_i, regdst_i,
        output regwrite_i, alures_i, memres_i,
        output out_ready, fwd_src_i,
        input  in_ready, out_valid, memtoreg_o, regdst_o,
        input  regwrite_o, alures_o, memres_o, wb_data_o,
        input  fwd_hit_o, occupancy_o
    );

endinterface

// File: rtl/mem_wb_stage_pipe_skid_entry.sv
// One pipeline holding register: valid bit plus payload.
// Clear drops the beat and forces masked bits to bubble values.
module pipe_skid_entry #(
    parameter int           W        = 8,
    parameter logic [W-1:0] RST_VAL  = '0,
    parameter logic [W-1:0] BUB_MASK = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load_i,
    input  logic         vld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d  = 1'b0;
            data_d = (data_q & ~BUB_MASK) | (RST_VAL & BUB_MASK);
        end else if (load_i) begin
            vld_d  = vld_i;
            data_d = d_i;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q  <= 1'b0;
            data_q <= RST_VAL;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage register with 2-entry skid, flush and bubbles.
// Also drives writeback data and forwarding hits to the hazard unit.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
    parameter int               DATA_W    = MW_DATA_W,
    parameter int               REG_W     = MW_REG_W,
    parameter logic [REG_W-1:0] NOP_DST   = '1,
    parameter int               SRC_PORTS = MW_SRC_N
) (
    input  logic CLK,
    input  logic RST,
    mem_wb_stage_if.slave bus
);

    typedef struct packed {
        logic              memtoreg;
        logic [REG_W-1:0]  regdst;
        logic              regwrite;
        logic [DATA_W-1:0] alures;
        logic [DATA_W-1:0] memres;
    } beat_t;

    localparam int BW = $bits(beat_t);

    localparam beat_t BUBBLE = '{
        memtoreg: 1'b0,
        regdst:   NOP_DST,
        regwrite: 1'b0,
        alures:   '0,
        memres:   '0
    };

    // Only control fields are bubbled; data fields survive a flush.
    localparam beat_t CTL_MASK = '{
        memtoreg: 1'b1,
        regdst:   '1,
        regwrite: 1'b1,
        alures:   '0,
        memres:   '0
    };

    beat_t in_beat, h_q, s_q, h_d, s_d;
    logic  h_vld, s_vld;
    logic  h_load, s_load, h_vin, s_vin;
    logic  accept, pop;

    assign in_beat = '{
        memtoreg: bus.memtoreg_i,
        regdst:   bus.regdst_i,
        regwrite: bus.regwrite_i,
        alures:   bus.alures_i,
        memres:   bus.memres_i
    };

    assign bus.in_ready = !s_vld;
    assign accept = bus.in_valid & !s_vld & !bus.flush;
    assign pop    = h_vld & bus.out_ready;

    always_comb begin
        h_load = 1'b0;
        h_vin  = h_vld;
        h_d    = h_q;
        s_load = 1'b0;
        s_vin  = s_vld;
        s_d    = s_q;
        if (!bus.flush) begin
            if (pop) begin
                h_load = 1'b1;
                h_vin  = s_vld;
                h_d    = s_q;
                s_load = 1'b1;
                s_vin  = 1'b0;
            end
            // accept implies S empty, so a popped head refills directly
            if (accept && (!h_vld || pop)) begin
                h_load = 1'b1;
                h_vin  = 1'b1;
                h_d    = in_beat;
            end else if (accept) begin
                s_load = 1'b1;
                s_vin  = 1'b1;
                s_d    = in_beat;
            end
        end
    end

    pipe_skid_entry #(
        .W        (BW),
        .RST_VAL  (BUBBLE),
        .BUB_MASK (CTL_MASK)
    ) u_head (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (h_load),
        .vld_i  (h_vin),
        .clr_i  (bus.flush),
        .d_i    (h_d),
        .vld_o  (h_vld),
        .q_o    (h_q)
    );

    pipe_skid_entry #(
        .W        (BW),
        .RST_VAL  (BUBBLE),
        .BUB_MASK (CTL_MASK)
    ) u_skid (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (s_load),
        .vld_i  (s_vin),
        .clr_i  (bus.flush),
        .d_i    (s_d),
        .vld_o  (s_vld),
        .q_o    (s_q)
    );

    assign bus.out_valid  = h_vld;
    assign bus.memtoreg_o = h_q.memtoreg & h_vld;
    assign bus.regwrite_o = h_q.regwrite & h_vld;
    assign bus.regdst_o   = h_vld ? h_q.regdst : NOP_DST;
    assign bus.alures_o   = h_q.alures;
    assign bus.memres_o   = h_q.memres;
    assign bus.wb_data_o  = bus.memtoreg_o ? h_q.memres
                                           : h_q.alures;

    assign bus.occupancy_o = {1'b0, h_vld} + {1'b0, s_vld};

    for (genvar k = 0; k < SRC_PORTS; k++) begin : g_fwd
        logic [REG_W-1:0] src;
        assign src = bus.fwd_src_i[k*REG_W +: REG_W];
        assign bus.fwd_hit_o[k] = h_vld & h_q.regwrite
                                & (h_q.regdst == src)
                                & (src != NOP_DST);
    end

    a_skid_implies_head: assert property (
        @(posedge CLK) disable iff (!RST) s_vld |-> h_vld
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: queue model of held beats
// checked against outputs every cycle, plus directed corner cases.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int DW = MW_DATA_W;
    localparam int RW = MW_REG_W;
    localparam int SP = 2;

    typedef logic [SP*RW-1:0] src_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    mem_wb_stage_if #(
        .DATA_W(DW), .REG_W(RW), .SRC_PORTS(SP)
    ) bus ();

    mem_wb_stage #(
        .DATA_W(DW), .REG_W(RW),
        .NOP_DST(MW_NOP_DST), .SRC_PORTS(SP)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int       total = 0;
    int       bad   = 0;
    mw_beat_t q[$];

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mw_beat_t mk(logic m, logic [RW-1:0] d,
                                    logic w, logic [DW-1:0] a,
                                    logic [DW-1:0] b);
        return '{memtoreg: m, regdst: d, regwrite: w,
                 alures: a, memres: b};
    endfunction

    function automatic mw_beat_t rnd();
        return mk(1'($urandom), RW'($urandom), 1'($urandom),
                  DW'($urandom), DW'($urandom));
    endfunction

    task automatic drive(logic v, mw_beat_t b, logic ordy,
                         logic fl, src_t src);
        bus.in_valid   = v;
        bus.memtoreg_i = b.memtoreg;
        bus.regdst_i   = b.regdst;
        bus.regwrite_i = b.regwrite;
        bus.alures_i   = b.alures;
        bus.memres_i   = b.memres;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        bus.fwd_src_i  = src;
    endtask

    task automatic check_out();
        int n = q.size();
        logic [SP-1:0] hit;
        logic [RW-1:0] s;
        chk("occupancy", 64'(bus.occupancy_o), 64'(n));
        chk("in_ready", 64'(bus.in_ready), 64'(n < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
        if (n > 0) begin
            chk("memtoreg", 64'(bus.memtoreg_o), 64'(q[0].memtoreg));
            chk("regdst", 64'(bus.regdst_o), 64'(q[0].regdst));
            chk("regwrite", 64'(bus.regwrite_o), 64'(q[0].regwrite));
            chk("alures", 64'(bus.alures_o), 64'(q[0].alures));
            chk("memres", 64'(bus.memres_o), 64'(q[0].memres));
            chk("wb_data", 64'(bus.wb_data_o),
                64'(q[0].memtoreg ? q[0].memres : q[0].alures));
        end else begin
            chk("idle_regdst", 64'(bus.regdst_o), 64'(MW_NOP_DST));
            chk("idle_regwrite", 64'(bus.regwrite_o), 64'd0);
            chk("idle_memtoreg", 64'(bus.memtoreg_o), 64'd0);
        end
        for (int k = 0; k < SP; k++) begin
            s = bus.fwd_src_i[k*RW +: RW];
            hit[k] = (n > 0) && q[0].regwrite
                  && (q[0].regdst == s) && (s != MW_NOP_DST);
        end
        chk("fwd_hit", 64'(bus.fwd_hit_o), 64'(hit));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic cyc(logic v, mw_beat_t b, logic ordy,
                       logic fl, src_t src);
        logic acc, pop;
        drive(v, b, ordy, fl, src);
        #1;
        check_out();
        acc = v && (q.size() < 2) && !fl;
        pop = (q.size() > 0) && ordy;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        @(negedge CLK);
    endtask

    initial begin
        mw_beat_t bA, bB, bC;
        src_t src;
        drive(1'b1, rnd(), 1'b1, 1'b0, src_t'($urandom));
        repeat (2) @(negedge CLK);
        drive(1'b1, rnd(), 1'b0, 1'b0, src_t'($urandom));
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_regdst", 64'(bus.regdst_o), 64'hF);
        chk("rst_regwrite", 64'(bus.regwrite_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_occupancy", 64'(bus.occupancy_o), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data_o), 64'd0);
        chk("rst_fwd", 64'(bus.fwd_hit_o), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 1; i <= 4; i++)
            cyc(1'b1, mk(0, RW'(i), 1, DW'(i), 16'h0),
                1'b1, 1'b0, '0);
        repeat (2) cyc(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);

        bA = mk(0, 4'd3, 1, 16'hAAAA, 16'h1111);
        bB = mk(1, 4'd5, 1, 16'hBBBB, 16'h2222);
        bC = mk(0, 4'd9, 1, 16'hCCCC, 16'h3333);
        cyc(1'b1, bA, 1'b0, 1'b0, '0);
        cyc(1'b1, bB, 1'b0, 1'b0, '0);
        cyc(1'b1, bC, 1'b0, 1'b0, '0);
        repeat (3) cyc(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);

        cyc(1'b1, bA, 1'b0, 1'b0, '0);
        cyc(1'b1, bB, 1'b0, 1'b0, '0);
        cyc(1'b1, bC, 1'b1, 1'b1, '0);
        drive(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);
        #1;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_occ", 64'(bus.occupancy_o), 64'd0);
        chk("flush_regdst", 64'(bus.regdst_o), 64'hF);
        @(negedge CLK);
        repeat (2) cyc(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);

        cyc(1'b1, mk(1, 4'd2, 1, 16'h1234, 16'hBEEF),
            1'b0, 1'b0, '0);
        drive(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);
        #1;
        chk("wb_mem", 64'(bus.wb_data_o), 64'hBEEF);
        @(negedge CLK);
        void'(q.pop_front());
        cyc(1'b1, mk(0, 4'd2, 1, 16'h1234, 16'hBEEF),
            1'b1, 1'b0, '0);
        drive(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);
        #1;
        chk("wb_alu", 64'(bus.wb_data_o), 64'h1234);
        @(negedge CLK);
        void'(q.pop_front());

        src = {4'd15, 4'd7};
        cyc(1'b1, mk(0, 4'd7, 1, 16'h7, 16'h0), 1'b0, 1'b0, src);
        drive(1'b0, MW_BUBBLE, 1'b0, 1'b0, src);
        #1;
        chk("fwd_hit_7", 64'(bus.fwd_hit_o), 64'b01);
        @(negedge CLK);
        cyc(1'b1, mk(0, 4'd7, 0, 16'h7, 16'h0), 1'b1, 1'b0, src);
        drive(1'b0, MW_BUBBLE, 1'b0, 1'b0, src);
        #1;
        chk("fwd_nowr", 64'(bus.fwd_hit_o), 64'b00);
        @(negedge CLK);
        src = {4'd15, 4'd15};
        cyc(1'b1, mk(0, 4'd15, 1, 16'hF, 16'h0), 1'b1, 1'b0, src);
        drive(1'b0, MW_BUBBLE, 1'b0, 1'b0, src);
        #1;
        chk("fwd_nop", 64'(bus.fwd_hit_o), 64'b00);
        @(negedge CLK);
        repeat (2) cyc(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            src = src_t'($urandom);
            if (q.size() > 0 && $urandom_range(1, 0) == 1)
                src[RW-1:0] = q[0].regdst;
            cyc(1'($urandom_range(3, 0) != 0), rnd(),
                1'($urandom_range(2, 0) != 0),
                1'($urandom_range(15, 0) == 0), src);
        end

        cyc(1'b1, bA, 1'b0, 1'b0, '0);
        cyc(1'b1, bB, 1'b0, 1'b0, '0);
        drive(1'b0, MW_BUBBLE, 1'b0, 1'b0, '0);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_occ", 64'(bus.occupancy_o), 64'd0);
        chk("arst_regdst", 64'(bus.regdst_o), 64'hF);
        q.delete();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) cyc(1'b0, MW_BUBBLE, 1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
